arcino_div_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32M divide/remainder group (DIV, DIVU, REM, REMU) in the ARCINO execute stage. It accepts one operation through a valid/ready handshake and handles the special cases in a single cycle. Other operations run a 32-iteration radix-2 restoring division, followed by a sign-correction cycle. The result is then held until the writeback side accepts it. Decode selects the block when the instruction has OPCODE_OP, funct7 = 0000001 and funct3[2] = 1.

---
 rtl/arcino_div_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_arcino_div_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arcino_div_ctrl.sv
// arcino_div_ctrl
// ---------------
// Sequencer for the RV32M divide/remainder group (DIV, DIVU, REM, REMU).
// One operation is accepted through a valid/ready handshake. Divide-by-zero
// and signed overflow finish in one cycle. Every other operation runs 32
// restoring radix-2 iterations and then one sign-correction cycle. The result
// is held until writeback accepts it.
//
// Ports:
//   clk_i        core clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operation request
//   in_ready_o   high while idle (combinational from state)
//   op_i         funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   op_a_i       dividend (rs1)
//   op_b_i       divisor (rs2)
//   kill_i       pipeline flush, aborts any in-flight or pending operation
//   out_valid_o  result available (registered)
//   out_ready_i  writeback accepts the result
//   result_o     quotient or remainder (registered)
//   busy_o       high whenever not idle
module arcino_div_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_reg,      state_next;
  logic [4:0]  cnt_reg,        cnt_next;
  logic [1:0]  op_reg,         op_next;
  logic        op_signed_reg,  op_signed_next;
  logic        a_neg_reg,      a_neg_next;
  logic        b_neg_reg,      b_neg_next;
  logic [31:0] quo_reg,        quo_next;
  logic [31:0] div_reg,        div_next;
  logic [32:0] rem_reg,        rem_next;
  logic [31:0] result_reg,     result_next;
  logic        out_valid_reg,  out_valid_next;

  // Decode of the incoming request
  logic        accept;
  logic        in_signed;
  logic        in_a_neg;
  logic        in_b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        div_zero;
  logic        sgn_ovf;

  // Datapath of one restoring iteration
  logic [32:0] rem_shift;
  logic [32:0] diff;

  // Sign correction
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;

  assign in_ready_o  = (state_reg == ST_IDLE);
  assign busy_o      = (state_reg != ST_IDLE);
  assign out_valid_o = out_valid_reg;
  assign result_o    = result_reg;

  assign accept    = in_valid_i & in_ready_o & ~kill_i;
  assign in_signed = ~op_i[0];
  assign in_a_neg  = in_signed & op_a_i[31];
  assign in_b_neg  = in_signed & op_b_i[31];
  // Two's complement of 0x80000000 is itself, which is the right unsigned magnitude
  assign abs_a     = in_a_neg ? (~op_a_i + 32'd1) : op_a_i;
  assign abs_b     = in_b_neg ? (~op_b_i + 32'd1) : op_b_i;
  assign div_zero  = (op_b_i == 32'd0);
  assign sgn_ovf   = in_signed & (op_a_i == 32'h8000_0000) & (op_b_i == 32'hFFFF_FFFF);

  // The partial remainder is always below the divisor, so its shifted value fits in 33 bits
  assign rem_shift = {rem_reg[31:0], quo_reg[31]};
  assign diff      = rem_shift - {1'b0, div_reg};

  assign quo_fixed = (op_signed_reg & (a_neg_reg ^ b_neg_reg)) ? (~quo_reg + 32'd1) : quo_reg;
  assign rem_fixed = (op_signed_reg & a_neg_reg) ? (~rem_reg[31:0] + 32'd1) : rem_reg[31:0];

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    op_next        = op_reg;
    op_signed_next = op_signed_reg;
    a_neg_next     = a_neg_reg;
    b_neg_next     = b_neg_reg;
    quo_next       = quo_reg;
    div_next       = div_reg;
    rem_next       = rem_reg;
    result_next    = result_reg;
    out_valid_next = out_valid_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          op_next        = op_i;
          op_signed_next = in_signed;
          a_neg_next     = in_a_neg;
          b_neg_next     = in_b_neg;
          if (div_zero) begin
            result_next    = op_i[1] ? op_a_i : 32'hFFFF_FFFF;
            out_valid_next = 1'b1;
            state_next     = ST_DONE;
          end else if (sgn_ovf) begin
            result_next    = op_i[1] ? 32'd0 : 32'h8000_0000;
            out_valid_next = 1'b1;
            state_next     = ST_DONE;
          end else begin
            quo_next   = abs_a;
            div_next   = abs_b;
            rem_next   = 33'd0;
            cnt_next   = 5'd0;
            state_next = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (!diff[32]) begin
          rem_next = diff;
          quo_next = {quo_reg[30:0], 1'b1};
        end else begin
          rem_next = rem_shift;
          quo_next = {quo_reg[30:0], 1'b0};
        end
        if (cnt_reg == 5'd31) begin
          state_next = ST_FIX;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end

      ST_FIX: begin
        result_next    = op_reg[1] ? rem_fixed : quo_fixed;
        out_valid_next = 1'b1;
        state_next     = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready_i) begin
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        state_next     = ST_IDLE;
        out_valid_next = 1'b0;
      end
    endcase

    // Flush overrides everything, including a pending writeback transfer
    if (kill_i) begin
      state_next     = ST_IDLE;
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 5'd0;
      op_reg        <= 2'd0;
      op_signed_reg <= 1'b0;
      a_neg_reg     <= 1'b0;
      b_neg_reg     <= 1'b0;
      quo_reg       <= 32'd0;
      div_reg       <= 32'd0;
      rem_reg       <= 33'd0;
      result_reg    <= 32'd0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op_reg        <= op_next;
      op_signed_reg <= op_signed_next;
      a_neg_reg     <= a_neg_next;
      b_neg_reg     <= b_neg_next;
      quo_reg       <= quo_next;
      div_reg       <= div_next;
      rem_reg       <= rem_next;
      result_reg    <= result_next;
      out_valid_reg <= out_valid_next;
    end
  end

endmodule

// File: tb/tb_arcino_div_ctrl.sv
// Self-checking bench for arcino_div_ctrl: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_arcino_div_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  op_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        kill_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  arcino_div_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .kill_i      (kill_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension divide semantics from plain arithmetic
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
      return op[1] ? r : q;
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one operation, measure latency, optionally hold backpressure, then accept
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp_res;
    int          exp_lat;
    int          n;
    exp_res = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    check({tag, ".in_ready"}, 32'(in_ready_o), 32'd1);
    in_valid_i  = 1'b1;
    op_i        = op;
    op_a_i      = a;
    op_b_i      = b;
    out_ready_i = 1'b0;
    tick();
    in_valid_i = 1'b0;
    n = 0;
    while (!out_valid_o && n < 40) begin
      tick();
      n++;
    end
    if (n == 0) begin
      tick();
      n++;
      while (!out_valid_o && n < 40) begin
        tick();
        n++;
      end
    end
    check({tag, ".latency"}, 32'(n), 32'(exp_lat));
    check({tag, ".result"}, result_o, exp_res);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold_result"}, result_o, exp_res);
      check({tag, ".hold_in_ready"}, 32'(in_ready_o), 32'd0);
      check({tag, ".hold_valid"}, 32'(out_valid_o), 32'd1);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check({tag, ".post_valid"}, 32'(out_valid_o), 32'd0);
    check({tag, ".post_in_ready"}, 32'(in_ready_o), 32'd1);
    $display("txn %s op=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d", tag, op, a, b,
             result_o, n);
  endtask

  // Ensure no result shows up for a while after an abort
  task automatic expect_silence(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid_o) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          sel;

    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    op_i        = 2'd0;
    op_a_i      = 32'd0;
    op_b_i      = 32'd0;
    kill_i      = 1'b0;
    out_ready_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    check("reset.in_ready", 32'(in_ready_o), 32'd1);
    check("reset.busy", 32'(busy_o), 32'd0);
    check("reset.out_valid", 32'(out_valid_o), 32'd0);
    check("reset.result", result_o, 32'd0);

    // Directed cases
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0);
    run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div_7_m2",   2'b00, 32'd7, 32'hFFFF_FFFE, 0);
    run_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 0);
    run_op("divu_by0",   2'b01, 32'd5, 32'd0, 0);
    run_op("rem_by0",    2'b10, 32'h8000_0000, 32'd0, 0);
    run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_ovfop", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div_min_2",  2'b00, 32'h8000_0000, 32'd2, 0);
    run_op("backpress",  2'b00, 32'd1000, 32'hFFFF_FFF3, 5);
    run_op("bp_fast",    2'b01, 32'd77, 32'd0, 3);

    // Request together with kill is not accepted
    in_valid_i = 1'b1;
    op_i       = 2'b01;
    op_a_i     = 32'd50;
    op_b_i     = 32'd5;
    kill_i     = 1'b1;
    tick();
    in_valid_i = 1'b0;
    kill_i     = 1'b0;
    check("valid_kill.busy", 32'(busy_o), 32'd0);
    check("valid_kill.in_ready", 32'(in_ready_o), 32'd1);
    expect_silence("valid_kill.no_result");

    // Kill at CALC iteration 10
    in_valid_i = 1'b1;
    op_i       = 2'b01;
    op_a_i     = 32'd1000;
    op_b_i     = 32'd7;
    tick();
    in_valid_i = 1'b0;
    repeat (9) tick();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    check("kill_calc.in_ready", 32'(in_ready_o), 32'd1);
    check("kill_calc.out_valid", 32'(out_valid_o), 32'd0);
    expect_silence("kill_calc.no_result");
    run_op("after_kill", 2'b01, 32'd9, 32'd3, 0);

    // Reset mid-CALC
    in_valid_i = 1'b1;
    op_i       = 2'b00;
    op_a_i     = 32'd12345;
    op_b_i     = 32'd11;
    tick();
    in_valid_i = 1'b0;
    repeat (15) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_calc.in_ready", 32'(in_ready_o), 32'd1);
    check("rst_calc.result", result_o, 32'd0);
    expect_silence("rst_calc.no_result");
    run_op("after_rst", 2'b01, 32'd9, 32'd3, 0);

    // Kill in DONE beats a simultaneous out_ready
    in_valid_i = 1'b1;
    op_i       = 2'b11;
    op_a_i     = 32'd20;
    op_b_i     = 32'd6;
    tick();
    in_valid_i = 1'b0;
    for (int i = 0; i < 40 && !out_valid_o; i++) tick();
    check("kill_done.valid_seen", 32'(out_valid_o), 32'd1);
    kill_i      = 1'b1;
    out_ready_i = 1'b1;
    tick();
    kill_i      = 1'b0;
    out_ready_i = 1'b0;
    check("kill_done.out_valid", 32'(out_valid_o), 32'd0);
    check("kill_done.in_ready", 32'(in_ready_o), 32'd1);
    expect_silence("kill_done.no_result");

    // Randomized operations, with corner operands mixed in
    for (int t = 0; t < 24; t++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) ra = 32'($urandom_range(0, 100));
      else if (sel == 4) rb = 32'hFFFF_FFFF;
      run_op($sformatf("rand%0d", t), rop, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
